// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared sizing constants and helpers for the FIFO pointer/flag controller
package fifo_ctrl_pkg;

  localparam int DEF_ADDR_SIZE = 10;
  localparam int DEF_AE_LEVEL  = 4;
  localparam int AF_MARGIN     = 4;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  // One extra bit so a completely full FIFO (count == depth) is representable
  function automatic int count_width(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic int def_af_level(input int addr_size);
    return fifo_depth(addr_size) - AF_MARGIN;
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, flag and FWFT read-address controller for the dual-port FIFO RAM
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int AF_LEVEL  = def_af_level(ADDR_SIZE),
  parameter int AE_LEVEL  = DEF_AE_LEVEL
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic                 rd,
  output logic                 we,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int            CW    = count_width(ADDR_SIZE);
  localparam logic [CW-1:0] DEPTH = CW'(fifo_depth(ADDR_SIZE));
  localparam logic [CW-1:0] AF_TH = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_TH = CW'(AE_LEVEL);

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] wr_ptr_next;
  logic [CW-1:0] rd_ptr_next;
  logic [CW-1:0] count_next;
  logic          wr_ok;
  logic          rd_ok;

  // Requests are masked while rst is held so the RAM sees no write and a zero read address
  always_comb begin
    wr_ok       = wr & ~full & ~rst;
    rd_ok       = rd & ~empty & ~rst;
    wr_ptr_next = wr_ptr + CW'(wr_ok);
    rd_ptr_next = rd_ptr + CW'(rd_ok);
    // Pointer difference equals count + wr_ok - rd_ok; the wrap bits separate full from empty
    count_next  = wr_ptr_next - rd_ptr_next;
  end

  assign we     = wr_ok;
  assign w_addr = wr_ptr[ADDR_SIZE-1:0];
  // Presenting the post-pop head address lets the RAM's address register land on it at the edge
  assign r_addr = rd_ptr_next[ADDR_SIZE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_next;
      rd_ptr       <= rd_ptr_next;
      count        <= count_next;
      full         <= (count_next == DEPTH);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_TH);
      almost_empty <= (count_next <= AE_TH);
      overflow     <= overflow | (wr & full);
      underflow    <= underflow | (rd & empty);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - table-driven bench for fifo_ctrl with a small FWFT RAM model
module tb_fifo_ctrl;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [7:0]    wdata = 8'h00;
  logic          we;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  logic [7:0]    mem [4];
  logic [AW-1:0] raddr_q = '0;
  logic [7:0]    rdata;

  int tests  = 0;
  int failed = 0;

  fifo_ctrl #(.ADDR_SIZE(AW), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd),
    .we(we), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // RAM: registered read address, asynchronous array read
  always @(posedge clk) begin
    if (we) mem[w_addr] <= wdata;
    raddr_q <= r_addr;
  end
  assign rdata = mem[raddr_q];

  typedef struct {
    logic       wr, rd;
    logic [7:0] wd;
    logic       we;
    logic [1:0] waddr, raddr;
    logic [2:0] cnt;
    logic       full, empty, af, ae, ovf, udf, chk;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic r, input logic [7:0] wd,
                              input logic e_we, input logic [1:0] wa, input logic [1:0] ra,
                              input logic [2:0] c, input logic f, input logic em,
                              input logic af, input logic ae, input logic ov, input logic ud,
                              input logic ck, input logic [7:0] d);
    vec_t v;
    v.wr = w; v.rd = r; v.wd = wd; v.we = e_we; v.waddr = wa; v.raddr = ra;
    v.cnt = c; v.full = f; v.empty = em; v.af = af; v.ae = ae; v.ovf = ov; v.udf = ud;
    v.chk = ck; v.data = d;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_invariants(input int idx);
    logic [2:0] diff;
    diff = dut.wr_ptr - dut.rd_ptr;
    cmp("count_vs_ptrs", idx, 32'(count), 32'(diff));
    cmp("not_full_and_empty", idx, 32'(full & empty), 32'd0);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    wr = v.wr; rd = v.rd; wdata = v.wd;
    #1;
    cmp("we", idx, 32'(we), 32'(v.we));
    cmp("w_addr", idx, 32'(w_addr), 32'(v.waddr));
    cmp("r_addr", idx, 32'(r_addr), 32'(v.raddr));
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    cmp("count", idx, 32'(count), 32'(v.cnt));
    cmp("full", idx, 32'(full), 32'(v.full));
    cmp("empty", idx, 32'(empty), 32'(v.empty));
    cmp("almost_full", idx, 32'(almost_full), 32'(v.af));
    cmp("almost_empty", idx, 32'(almost_empty), 32'(v.ae));
    cmp("overflow", idx, 32'(overflow), 32'(v.ovf));
    cmp("underflow", idx, 32'(underflow), 32'(v.udf));
    if (v.chk) cmp("rdata", idx, 32'(rdata), 32'(v.data));
    check_invariants(idx);
  endtask

  task automatic check_reset_state(input int idx);
    cmp("rst_count", idx, 32'(count), 32'd0);
    cmp("rst_empty", idx, 32'(empty), 32'd1);
    cmp("rst_almost_empty", idx, 32'(almost_empty), 32'd1);
    cmp("rst_full", idx, 32'(full), 32'd0);
    cmp("rst_almost_full", idx, 32'(almost_full), 32'd0);
    cmp("rst_overflow", idx, 32'(overflow), 32'd0);
    cmp("rst_underflow", idx, 32'(underflow), 32'd0);
    cmp("rst_r_addr", idx, 32'(r_addr), 32'd0);
    cmp("rst_we", idx, 32'(we), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset with requests asserted: outputs must still show the idle state
    #1 rst = 1'b1; wr = 1'b1; rd = 1'b1;
    #1 check_reset_state(-1);
    wr = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check_reset_state(-2);

    //          wr rd wd     we wa ra cnt f e af ae ov ud ck data
    vecs.push_back(mk(1, 0, 8'hA1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 8'hA1));
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 0, 8'h10, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 8'h10));
    vecs.push_back(mk(1, 0, 8'h11, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(1, 0, 8'h12, 1, 3, 1, 3, 0, 0, 1, 0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(1, 0, 8'h13, 1, 0, 1, 4, 1, 0, 1, 0, 0, 0, 1, 8'h10));
    vecs.push_back(mk(1, 0, 8'h99, 0, 1, 1, 4, 1, 0, 1, 0, 1, 0, 1, 8'h10));
    vecs.push_back(mk(1, 1, 8'h98, 0, 1, 2, 3, 0, 0, 1, 0, 1, 0, 1, 8'h11));
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 3, 2, 0, 0, 0, 0, 1, 0, 1, 8'h12));
    // Streaming at constant occupancy 2: both pointers wrap through address 0
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk(1, 1, 8'(8'h20 + k), 1, 2'((1 + k) % 4), 2'(k % 4),
                        2, 0, 0, 0, 0, 1, 0, 1,
                        (k == 0) ? 8'h13 : 8'(8'h20 + k - 1)));
    end
    vecs.push_back(mk(0, 1, 8'h00, 0, 3, 2, 1, 0, 0, 0, 1, 1, 0, 1, 8'h29));
    vecs.push_back(mk(0, 1, 8'h00, 0, 3, 3, 0, 0, 1, 0, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 8'h55, 1, 3, 3, 1, 0, 0, 0, 1, 1, 1, 1, 8'h55));

    foreach (vecs[i]) apply(vecs[i], i);

    // Asynchronous reset mid-stream, between clock edges
    @(negedge clk);
    wr = 1'b1; wdata = 8'h66;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state(100);
    wr = 1'b0;
    @(negedge clk) rst = 1'b0;

    apply(mk(1, 0, 8'h77, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 8'h77), 101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

- Pointer and flag controller for the team's dual-port FIFO RAM (registered read address, asynchronous array read).
- Accepts write/read requests and generates the RAM write address, write enable and read address.
- Maintains occupancy count, full/empty/almost flags and sticky overflow/underflow errors.
- Drives the RAM read address so the head word appears on the RAM read-data port as first-word-fall-through (FWFT).

## Interface
Parameters:
- ADDR_SIZE, 10, RAM address width; depth = 2**ADDR_SIZE
- AF_LEVEL, 2**ADDR_SIZE - 4, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr  in  1  write request
- rd  in  1  read request (pop head word)
- we  out  1  RAM write enable
- w_addr  out  ADDR_SIZE  RAM write address
- r_addr  out  ADDR_SIZE  RAM read address (RAM registers it internally)
- full  out  1  registered
- empty  out  1  registered
- almost_full  out  1  registered
- almost_empty  out  1  registered
- count  out  ADDR_SIZE+1  registered occupancy, 0..2**ADDR_SIZE
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Internal pointers: wr_ptr and rd_ptr, ADDR_SIZE+1 bits each.
  - MSB is the wrap bit; the low ADDR_SIZE bits address the RAM.
- Request acceptance:
  - wr_ok = wr & ~full
  - rd_ok = rd & ~empty
  - Both are evaluated against the current registered flags.
- Write path:
  - we = wr_ok (combinational)
  - w_addr = wr_ptr[ADDR_SIZE-1:0]
- Read path (FWFT):
  - r_addr = (rd_ptr + rd_ok)[ADDR_SIZE-1:0], combinational.
  - After each edge, the RAM's registered address equals the new head.
- Pointer update on each edge:
  - wr_ptr += wr_ok
  - rd_ptr += rd_ok
  - Both wrap naturally modulo 2**(ADDR_SIZE+1).
- Count update:
  - count_next = count + wr_ok - rd_ok, exact, never outside 0..2**ADDR_SIZE.
  - count, full, empty, almost_full and almost_empty all register from count_next.
  - full = (count_next == 2**ADDR_SIZE)
  - empty = (count_next == 0)
- Error flags:
  - overflow sets on wr & full; underflow sets on rd & empty.
  - Both are cleared only by rst.
- Simultaneous events:
  - wr & rd while neither full nor empty: both accepted, count unchanged.
  - wr & rd while full: read accepted, write rejected, overflow set; count drops by 1.
  - wr & rd while empty: write accepted, read rejected, underflow set; count rises by 1.
- No state machine; behaviour is fully defined by the two pointers and the registered flags.

## Timing
- Reset (asynchronous, immediate):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0, overflow = 0, underflow = 0
  - r_addr = 0, we = 0
- Reset mid-operation discards all contents; the RAM array is not cleared.
- Write-to-read latency:
  - A word written at edge N is visible on RAM read data after edge N, including into an empty FIFO.
  - empty deasserts after the same edge N; no extra bubble.
- Read latency:
  - After rd_ok at edge N, the next word is on RAM read data after edge N.
  - The consumer samples read data whenever ~empty.
- Flags change only on clock edges; they never glitch combinationally.
- Wrap-around:
  - Address returns to 0 after 2**ADDR_SIZE-1.
  - Full is distinguished from empty by differing pointer MSBs (cross-check of count).

## Structure
- Shared constants header holds:
  - the depth expression 2**ADDR_SIZE
  - default AF_LEVEL / AE_LEVEL
  - count width ADDR_SIZE+1
- No sub-module inside fifo_ctrl; pointer increment is inline.
- The parent FIFO top instantiates fifo_ctrl alongside the RAM: we, w_addr and r_addr connect directly.
- Bench assertions:
  - count == wr_ptr - rd_ptr
  - ~(full & empty)

## Test plan
Tests use ADDR_SIZE=2, AF_LEVEL=3, AE_LEVEL=1.
- Reset then idle:
  - Outputs: empty=1, almost_empty=1, full=0, count=0, r_addr=0, we=0, overflow=0, underflow=0.
- Write 0xA1 once:
  - Next cycle: empty=0, count=1, RAM read data=0xA1.
  - w_addr was 0 with we=1 during the write cycle.
- Write 4 words (0x10..0x13):
  - full=1 and almost_full=1 after the 4th edge, count=4.
  - 5th wr: we=0, overflow=1, count stays 4.
- From full, assert wr and rd together:
  - Read accepted, write rejected; count=3, full=0, overflow=1.
  - Head becomes 0x11.
- Wrap-around: stream 10 words with wr & rd overlapping at count 2:
  - Read order equals write order.
  - w_addr sequence wraps 3→0.
  - count stays 2 throughout.
- Empty with wr & rd together:
  - Write accepted, underflow=1, count=1.
  - Assert rst mid-stream: count=0 and empty=1 immediately, without a clock edge.
